// File: rtl/btn_ctrl_pkg.sv
// Shared constants for the button peripheral: register offsets, default sizing
// and the Bridge address decode for the button window.
package btn_ctrl_pkg;

  localparam int N_BTN_DEFAULT    = 5;
  localparam int DEBOUNCE_DEFAULT = 200000;
  localparam int CNT_W_DEFAULT    = 18;

  typedef enum logic [1:0] {
    BTN_OFF_LEVEL = 2'd0,
    BTN_OFF_EVENT = 2'd1,
    BTN_OFF_MASK  = 2'd2,
    BTN_OFF_RSVD  = 2'd3
  } btn_off_e;

  // The Bridge selects this block when the word address falls in a 16-byte window.
  localparam logic [31:0] BTN_WIN_BASE = 32'hFFFF_FC70;
  localparam logic [31:0] BTN_WIN_MASK = 32'hFFFF_FFF0;

  function automatic logic btn_addr_hit(input logic [31:0] addr);
    return (addr & BTN_WIN_MASK) == BTN_WIN_BASE;
  endfunction

endpackage

// File: rtl/btn_ctrl_debounce.sv
// One button: 2-FF synchronizer, run-length debounce counter and stable level.
// rise/fall are combinational pulses valid on the edge where stable changes.
module btn_debounce
  import btn_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int CNT_W           = CNT_W_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic stable,
  output logic rise,
  output logic fall
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;

  always_comb begin
    s1_d     = btn_in;
    s2_d     = s1_q;
    stable_d = stable_q;
    cnt_d    = cnt_q;
    accept   = 1'b0;
    if (s2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      accept   = 1'b1;
      stable_d = s2_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable = stable_q;
  assign rise   = accept & s2_q;
  assign fall   = accept & ~s2_q;

endmodule

// File: rtl/btn_ctrl.sv
// Memory-mapped button block: debounced levels, sticky W1C press/release events,
// event mask and a registered level interrupt. Read data is combinational.
module btn_ctrl
  import btn_ctrl_pkg::*;
#(
  parameter int N_BTN           = N_BTN_DEFAULT,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int CNT_W           = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] button,
  input  logic [1:0]       addr_off,
  input  logic             wen,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  output logic             irq
);

  logic [N_BTN-1:0]   stable, rise, fall;
  logic [N_BTN-1:0]   press_q, press_d;
  logic [N_BTN-1:0]   rel_q, rel_d;
  logic [2*N_BTN-1:0] mask_q, mask_d;
  logic               irq_q, irq_d;
  logic [31:0]        wdata_unused;
  btn_off_e           off;

  assign off          = btn_off_e'(addr_off);
  assign wdata_unused = wdata;

  generate
    for (genvar gi = 0; gi < N_BTN; gi++) begin : g_btn
      btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
      ) u_debounce (
        .clk   (clk),
        .rst   (rst),
        .btn_in(button[gi]),
        .stable(stable[gi]),
        .rise  (rise[gi]),
        .fall  (fall[gi])
      );
    end
  endgenerate

  always_comb begin
    press_d = press_q;
    rel_d   = rel_q;
    mask_d  = mask_q;
    if (wen && off == BTN_OFF_EVENT) begin
      press_d = press_q & ~wdata[N_BTN-1:0];
      rel_d   = rel_q & ~wdata[2*N_BTN-1:N_BTN];
    end
    if (wen && off == BTN_OFF_MASK) begin
      mask_d = wdata[2*N_BTN-1:0];
    end
    // New events are OR-ed after the clear so a same-cycle set survives W1C.
    press_d = press_d | rise;
    rel_d   = rel_d | fall;
    irq_d   = |({rel_q, press_q} & mask_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      press_q <= '0;
      rel_q   <= '0;
      mask_q  <= '0;
      irq_q   <= 1'b0;
    end else begin
      press_q <= press_d;
      rel_q   <= rel_d;
      mask_q  <= mask_d;
      irq_q   <= irq_d;
    end
  end

  always_comb begin
    rdata = '0;
    case (off)
      BTN_OFF_LEVEL: rdata[N_BTN-1:0]   = stable;
      BTN_OFF_EVENT: rdata[2*N_BTN-1:0] = {rel_q, press_q};
      BTN_OFF_MASK:  rdata[2*N_BTN-1:0] = mask_q;
      default:       rdata = '0;
    endcase
  end

  assign irq = irq_q;

endmodule

// File: tb/tb_btn_ctrl.sv
// Bench for btn_ctrl: directed walk through the key scenarios, then random
// buttons/writes/resets compared every cycle against a sample-window model.
module tb_btn_ctrl;

  localparam int N  = 5;
  localparam int D  = 4;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  button;
  logic [1:0]    addr_off;
  logic          wen;
  logic [31:0]   wdata;
  logic [31:0]   rdata;
  logic          irq;

  btn_ctrl #(
    .N_BTN          (N),
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (CW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .button  (button),
    .addr_off(addr_off),
    .wen     (wen),
    .wdata   (wdata),
    .rdata   (rdata),
    .irq     (irq)
  );

  always #10 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: a level flips once the last D synchronized samples all
  // disagree with it; samples reach the debouncer two edges after the pin.
  logic [N-1:0]   hist[$];
  logic [N-1:0]   m_level, m_press, m_rel;
  logic [2*N-1:0] m_mask;
  logic           m_irq;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    hist.delete();
    for (int k = 0; k <= D; k++) hist.push_back('0);
    m_level = '0;
    m_press = '0;
    m_rel   = '0;
    m_mask  = '0;
    m_irq   = 1'b0;
  endfunction

  function automatic void model_edge();
    logic [N-1:0] rise_m, fall_m, lvl_next;
    logic         irq_next;
    if (rst) begin
      model_reset();
      return;
    end
    rise_m   = '0;
    fall_m   = '0;
    lvl_next = m_level;
    irq_next = |({m_rel, m_press} & m_mask);
    for (int i = 0; i < N; i++) begin
      bit all_diff = 1'b1;
      for (int k = 2; k <= D + 1; k++)
        if (hist[hist.size() - k][i] == m_level[i]) all_diff = 1'b0;
      if (all_diff) begin
        lvl_next[i] = ~m_level[i];
        if (lvl_next[i]) rise_m[i] = 1'b1;
        else             fall_m[i] = 1'b1;
      end
    end
    hist.push_back(button);
    if (hist.size() > D + 2) void'(hist.pop_front());
    if (wen && addr_off == 2'd1) begin
      m_press = m_press & ~wdata[N-1:0];
      m_rel   = m_rel & ~wdata[2*N-1:N];
    end
    if (wen && addr_off == 2'd2) m_mask = wdata[2*N-1:0];
    m_press = m_press | rise_m;
    m_rel   = m_rel | fall_m;
    m_level = lvl_next;
    m_irq   = irq_next;
  endfunction

  function automatic logic [31:0] exp_rd(input int off);
    logic [31:0] v = '0;
    case (off)
      0: v[N-1:0]   = m_level;
      1: v[2*N-1:0] = {m_rel, m_press};
      2: v[2*N-1:0] = m_mask;
      default: v = '0;
    endcase
    return v;
  endfunction

  task automatic rd(input int off, output logic [31:0] v);
    addr_off = 2'(off);
    #1;
    v = rdata;
  endtask

  task automatic check_all();
    logic [31:0] v;
    for (int o = 0; o < 4; o++) begin
      rd(o, v);
      check($sformatf("model_rd%0d", o), v, exp_rd(o));
    end
    check("model_irq", {31'd0, irq}, {31'd0, m_irq});
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    wen = 1'b0;
    check_all();
  endtask

  task automatic bus_write(input int off, input logic [31:0] data);
    addr_off = 2'(off);
    wdata    = data;
    wen      = 1'b1;
    $display("write off=%0d data=0x%08h at %0t", off, data, $time);
    step();
  endtask

  initial begin
    logic [31:0] v;
    rst = 1'b1; button = '0; addr_off = '0; wen = 1'b0; wdata = '0;
    model_reset();
    step();
    step();
    rst = 1'b0;

    for (int o = 0; o < 4; o++) begin
      rd(o, v);
      check($sformatf("reset_rd%0d", o), v, 32'h0);
    end
    check("reset_irq", {31'd0, irq}, 32'h0);

    // 3-cycle glitch on button 0 must never be accepted
    button[0] = 1'b1;
    repeat (3) step();
    button[0] = 1'b0;
    for (int c = 0; c < 20; c++) begin
      step();
      rd(0, v); check("glitch_level", v, 32'h0);
      rd(1, v); check("glitch_event", v, 32'h0);
    end

    button[2] = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      step();
      rd(0, v);
      check($sformatf("press_level_edge%0d", e), v, (e >= 6) ? 32'h4 : 32'h0);
    end
    rd(1, v); check("press_event", v, 32'h004);

    bus_write(2, 32'h004);
    check("irq_after_mask_edge", {31'd0, irq}, 32'h0);
    step();
    check("irq_mask_plus1", {31'd0, irq}, 32'h1);
    bus_write(1, 32'h004);
    rd(1, v); check("w1c_event", v, 32'h0);
    check("irq_still_high", {31'd0, irq}, 32'h1);
    step();
    check("irq_dropped", {31'd0, irq}, 32'h0);

    button[2] = 1'b0;
    repeat (6) step();
    rd(1, v); check("release_event", v, 32'h080);
    rd(0, v); check("release_level", v, 32'h0);

    button[2] = 1'b1;
    repeat (6) step();
    rd(1, v); check("repress_event", v, 32'h084);
    button[2] = 1'b0;
    repeat (5) step();
    bus_write(1, 32'h080);
    rd(1, v); check("set_wins_over_w1c", v, 32'h084);

    button[4] = 1'b1;
    repeat (4) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int o = 0; o < 4; o++) begin
      rd(o, v);
      check($sformatf("midcount_rst_rd%0d", o), v, 32'h0);
    end
    for (int e = 1; e <= 6; e++) begin
      step();
      rd(1, v);
      check($sformatf("post_rst_event_edge%0d", e), v, (e >= 6) ? 32'h010 : 32'h0);
    end

    // Random phase: toggles, glitches, writes to every offset, sporadic resets
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 5) == 0) begin
        int b = $urandom_range(0, N - 1);
        button[b] = ~button[b];
      end
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 7) == 0)
        bus_write($urandom_range(0, 3),
                  ($urandom_range(0, 1) == 1) ? 32'($urandom) : 32'($urandom_range(0, 1023)));
      else
        step();
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
